// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
//
// Shared definitions for the instruction fetch memory:
//   - default parameter values for the fetch memory and its storage array
//   - the response fault code returned alongside every fetched word
//   - the legal bounds for the accept-to-response latency
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

  // Default geometry of the fetch memory.
  localparam int DEF_WORD_W  = 32;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;

  // Accept-to-response latency bounds (in clock cycles).
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Response fault code; FAULT_OK responses carry the fetched word,
  // any other code forces the data to zero.
  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

endpackage : instruction_fetch_pkg

// File: rtl/imem_storage_array.sv
// ----------------------------------------------------------------------------
// imem_storage_array
//
// Instruction word storage: DEPTH words of WORD_W bits with one synchronous
// read port (with enable) and one synchronous write port.
//
// A read and a write to the same index on the same edge return the old word:
// both updates are non-blocking, so the read samples the array before the
// write lands. The array has no reset; contents survive a reset of the
// surrounding logic.
//
// Ports:
//   clk      rising-edge clock
//   rd_en    read enable; rd_data holds its value while low
//   rd_idx   word index to read
//   rd_data  registered read data (valid one cycle after rd_en)
//   wr_en    write strobe
//   wr_idx   word index to write
//   wr_data  word to write
// ----------------------------------------------------------------------------
module imem_storage_array
  import instruction_fetch_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WORD_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WORD_W-1:0]        wr_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule : imem_storage_array

// File: rtl/instruction_fetch_memory.sv
// ----------------------------------------------------------------------------
// instruction_fetch_memory
//
// Pipelined instruction fetch memory with a valid/ready request and response
// handshake, address fault detection, a program-load write port and a
// saturating count of accepted requests.
//
// A request accepted on an edge is answered LATENCY cycles later (1..4) when
// the consumer does not stall. Stage 1 is the registered read of the storage
// array; stages 2..LATENCY are plain delay registers. While a response is
// held (rsp_valid && !rsp_ready) every stage, including the storage read
// register, is frozen and no new request is accepted.
//
// Ports:
//   CLK          rising-edge clock
//   Reset        asynchronous active-high reset (pipeline and counter only)
//   req_valid    fetch request present
//   req_ready    request accepted on this edge when high with req_valid
//   Address      byte address of the fetch (ADDR_W bits)
//   rsp_valid    response present on Data / rsp_fault
//   rsp_ready    consumer takes the response
//   Data         fetched word, zero for faulted or absent responses
//   rsp_fault    00 ok, 01 misaligned, 10 out of range
//   load_en      program-load write strobe (honoured even while stalled)
//   load_addr    word index for the load
//   load_data    word to store
//   fetch_count  saturating count of accepted requests
// ----------------------------------------------------------------------------
module instruction_fetch_memory
  import instruction_fetch_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        Address,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_W-1:0]        Data,
  output logic [1:0]               rsp_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WORD_W-1:0]        load_data,
  output logic [31:0]              fetch_count
);

  localparam int IDX_W = $clog2(DEPTH);

  // DEPTH widened to the word-index width so the range compare covers every
  // upper address bit; an out-of-range index must never alias a real word.
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

  // Misalignment wins over out of range.
  function automatic fault_e classify(input logic [ADDR_W-1:0] addr);
    if (addr[1:0] != 2'b00) begin
      return FAULT_MISALIGN;
    end
    if (addr[ADDR_W-1:2] >= DEPTH_LIM) begin
      return FAULT_RANGE;
    end
    return FAULT_OK;
  endfunction

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Only a present, fault-free response exposes the stored word.
  function automatic logic [WORD_W-1:0] mask_data(input logic [WORD_W-1:0] word,
                                                  input fault_e            code,
                                                  input logic              present);
    return (present && code == FAULT_OK) ? word : '0;
  endfunction

  logic              stall;
  logic              accept;
  logic              vld_p   [1:LATENCY];
  fault_e            fault_p [1:LATENCY];
  logic [WORD_W-1:0] rdata_p1;
  logic [WORD_W-1:0] data_last;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall && !Reset;
  assign accept    = req_valid && req_ready;

  // ---- Stage 1: storage read, registered inside the array ----
  // The read index is the low word-index bits; an out-of-range fetch reads
  // some word but the fault code masks it at the output.
  imem_storage_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk     (CLK),
    .rd_en   (!stall),
    .rd_idx  (Address[IDX_W+1:2]),
    .rd_data (rdata_p1),
    .wr_en   (load_en),
    .wr_idx  (load_addr),
    .wr_data (load_data)
  );

  // Valid and fault codes travel with the data; these are the only pipeline
  // registers cleared by Reset, which discards anything in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int s = 1; s <= LATENCY; s++) begin
        vld_p[s]   <= 1'b0;
        fault_p[s] <= FAULT_OK;
      end
    end else if (!stall) begin
      vld_p[1]   <= accept;
      fault_p[1] <= classify(Address);
      for (int s = 2; s <= LATENCY; s++) begin
        vld_p[s]   <= vld_p[s-1];
        fault_p[s] <= fault_p[s-1];
      end
    end
  end

  // ---- Stages 2..LATENCY: data delay registers ----
  generate
    if (LATENCY == 1) begin : g_direct
      assign data_last = rdata_p1;
    end else begin : g_stages
      logic [WORD_W-1:0] data_p [2:LATENCY];

      always_ff @(posedge CLK) begin
        if (!stall) begin
          data_p[2] <= rdata_p1;
          for (int s = 3; s <= LATENCY; s++) begin
            data_p[s] <= data_p[s-1];
          end
        end
      end

      assign data_last = data_p[LATENCY];
    end
  endgenerate

  // ---- Response outputs ----
  // Gating with rsp_valid keeps Data/rsp_fault at zero after reset and
  // between responses without resetting the data registers.
  assign rsp_valid = vld_p[LATENCY];
  assign Data      = mask_data(data_last, fault_p[LATENCY], rsp_valid);
  assign rsp_fault = rsp_valid ? fault_p[LATENCY] : FAULT_OK;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_count <= 32'd0;
    end else if (accept) begin
      fetch_count <= sat_inc(fetch_count);
    end
  end

endmodule : instruction_fetch_memory
